// File: rtl/pdua_control_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : pdua_control_unit_if
//  Purpose  : Control bundle between the PDUA control unit and its datapath.
//  Revision : 1.0  initial release
// ============================================================================
interface pdua_control_unit_if #(
    parameter int ADDR_WIDTH = 3
);
    logic [4:0]            out_IR;
    logic                  C;
    logic                  N;
    logic                  P;
    logic                  Z;
    logic                  wr_rdn;
    logic                  enaf;
    logic [2:0]            selop;
    logic [1:0]            shamt;
    logic                  bank_wr_en;
    logic [ADDR_WIDTH-1:0] BusB_addr;
    logic [ADDR_WIDTH-1:0] BusC_addr;
    logic                  sclr;
    logic                  ir_en;
    logic                  mar_en;
    logic                  mdr_en;
    logic                  mdr_alu_n;
    logic                  halted;
    logic                  illegal_op;

    // Control unit drives the strobes and consumes opcode and flags.
    modport master (
        input  out_IR, C, N, P, Z,
        output wr_rdn, enaf, selop, shamt, bank_wr_en, BusB_addr, BusC_addr,
               sclr, ir_en, mar_en, mdr_en, mdr_alu_n, halted, illegal_op
    );

    modport slave (
        output out_IR, C, N, P, Z,
        input  wr_rdn, enaf, selop, shamt, bank_wr_en, BusB_addr, BusC_addr,
               sclr, ir_en, mar_en, mdr_en, mdr_alu_n, halted, illegal_op
    );
endinterface
`default_nettype wire

// File: rtl/pdua_control_unit.sv
`default_nettype none
// ============================================================================
//  Module   : pdua_control_unit
//  Purpose  : Hardwired fetch/decode/execute FSM for the PDUA 8-bit datapath.
//  Revision : 1.0  initial release
// ============================================================================
module pdua_control_unit #(
    parameter int                    ADDR_WIDTH = 3,
    parameter logic [ADDR_WIDTH-1:0] PC_ADDR    = ADDR_WIDTH'(0),
    parameter logic [ADDR_WIDTH-1:0] ACC_ADDR   = ADDR_WIDTH'(3)
) (
    input  wire logic           clk,
    input  wire logic           rst,
    pdua_control_unit_if.master ctrl
);

    localparam logic [3:0] c_ST_INIT   = 4'd0;
    localparam logic [3:0] c_ST_F0     = 4'd1;
    localparam logic [3:0] c_ST_F1     = 4'd2;
    localparam logic [3:0] c_ST_F2     = 4'd3;
    localparam logic [3:0] c_ST_DECODE = 4'd4;
    localparam logic [3:0] c_ST_O0     = 4'd5;
    localparam logic [3:0] c_ST_O1     = 4'd6;
    localparam logic [3:0] c_ST_EX     = 4'd7;
    localparam logic [3:0] c_ST_SKIP   = 4'd8;
    localparam logic [3:0] c_ST_S0     = 4'd9;
    localparam logic [3:0] c_ST_S1     = 4'd10;
    localparam logic [3:0] c_ST_S2     = 4'd11;
    localparam logic [3:0] c_ST_HALT   = 4'd12;

    localparam logic [4:0] c_OP_NOP  = 5'b00000;
    localparam logic [4:0] c_OP_LDI  = 5'b00001;
    localparam logic [4:0] c_OP_ADDI = 5'b00010;
    localparam logic [4:0] c_OP_ANDI = 5'b00011;
    localparam logic [4:0] c_OP_NOT  = 5'b00100;
    localparam logic [4:0] c_OP_SHL  = 5'b00101;
    localparam logic [4:0] c_OP_JMP  = 5'b00110;
    localparam logic [4:0] c_OP_JZ   = 5'b00111;
    localparam logic [4:0] c_OP_STA  = 5'b01000;
    localparam logic [4:0] c_OP_HALT = 5'b11111;

    logic [3:0]            r_state;
    logic [3:0]            w_next;
    logic [4:0]            r_op;
    logic                  w_op_legal;
    logic                  w_unused_flags;

    logic                  w_wr_rdn;
    logic                  w_enaf;
    logic [2:0]            w_selop;
    logic [1:0]            w_shamt;
    logic                  w_bank_wr_en;
    logic [ADDR_WIDTH-1:0] w_busb;
    logic [ADDR_WIDTH-1:0] w_busc;
    logic                  w_sclr;
    logic                  w_ir_en;
    logic                  w_mar_en;
    logic                  w_mdr_en;
    logic                  w_mdr_alu_n;
    logic                  w_halted;
    logic                  w_illegal_op;

    assign w_op_legal     = (ctrl.out_IR <= c_OP_STA) || (ctrl.out_IR == c_OP_HALT);
    assign w_unused_flags = ^{ctrl.C, ctrl.N, ctrl.P};

    // The opcode is captured once in DECODE so later states ignore out_IR.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_INIT;
            r_op    <= c_OP_NOP;
        end else begin
            r_state <= w_next;
            if (r_state == c_ST_DECODE) begin
                r_op <= ctrl.out_IR;
            end
        end
    end

    always_comb begin
        w_next = c_ST_INIT;
        case (r_state)
            c_ST_INIT:   w_next = c_ST_F0;
            c_ST_F0:     w_next = c_ST_F1;
            c_ST_F1:     w_next = c_ST_F2;
            c_ST_F2:     w_next = c_ST_DECODE;
            c_ST_DECODE: begin
                if (!w_op_legal) begin
                    w_next = c_ST_F0;
                end else begin
                    case (ctrl.out_IR)
                        c_OP_NOP:           w_next = c_ST_F0;
                        c_OP_NOT, c_OP_SHL: w_next = c_ST_EX;
                        c_OP_JZ:            w_next = ctrl.Z ? c_ST_O0 : c_ST_SKIP;
                        c_OP_HALT:          w_next = c_ST_HALT;
                        default:            w_next = c_ST_O0;
                    endcase
                end
            end
            c_ST_O0:     w_next = c_ST_O1;
            c_ST_O1:     w_next = (r_op == c_OP_STA) ? c_ST_S0 : c_ST_EX;
            c_ST_EX:     w_next = c_ST_F0;
            c_ST_SKIP:   w_next = c_ST_F0;
            c_ST_S0:     w_next = c_ST_S1;
            c_ST_S1:     w_next = c_ST_S2;
            c_ST_S2:     w_next = c_ST_F0;
            c_ST_HALT:   w_next = c_ST_HALT;
            default:     w_next = c_ST_INIT;
        endcase
    end

    always_comb begin
        w_wr_rdn     = 1'b0;
        w_enaf       = 1'b0;
        w_selop      = 3'b000;
        w_shamt      = 2'b00;
        w_bank_wr_en = 1'b0;
        w_busb       = '0;
        w_busc       = '0;
        w_sclr       = 1'b0;
        w_ir_en      = 1'b0;
        w_mar_en     = 1'b0;
        w_mdr_en     = 1'b0;
        w_mdr_alu_n  = 1'b0;
        w_halted     = 1'b0;
        w_illegal_op = 1'b0;
        case (r_state)
            c_ST_INIT: w_sclr = 1'b1;
            c_ST_F0, c_ST_O0: begin
                w_busb   = PC_ADDR;
                w_mar_en = 1'b1;
            end
            // Memory read into MDR overlaps with PC++ through the ALU.
            c_ST_F1, c_ST_O1, c_ST_SKIP: begin
                w_mdr_en     = (r_state != c_ST_SKIP);
                w_mdr_alu_n  = (r_state != c_ST_SKIP);
                w_busb       = PC_ADDR;
                w_selop      = 3'b001;
                w_busc       = PC_ADDR;
                w_bank_wr_en = 1'b1;
            end
            c_ST_F2:     w_ir_en = 1'b1;
            c_ST_DECODE: w_illegal_op = !w_op_legal;
            c_ST_EX: begin
                w_bank_wr_en = 1'b1;
                w_busc       = ACC_ADDR;
                w_enaf       = 1'b1;
                case (r_op)
                    c_OP_LDI:  w_selop = 3'b110;
                    c_OP_ADDI: begin w_busb = ACC_ADDR; w_selop = 3'b010; end
                    c_OP_ANDI: begin w_busb = ACC_ADDR; w_selop = 3'b011; end
                    c_OP_NOT:  begin w_busb = ACC_ADDR; w_selop = 3'b100; end
                    c_OP_SHL: begin
                        w_busb  = ACC_ADDR;
                        w_selop = 3'b101;
                        w_shamt = 2'b01;
                    end
                    c_OP_JMP, c_OP_JZ: begin
                        w_selop = 3'b110;
                        w_busc  = PC_ADDR;
                        w_enaf  = 1'b0;
                    end
                    default: begin
                        w_bank_wr_en = 1'b0;
                        w_busc       = '0;
                        w_enaf       = 1'b0;
                    end
                endcase
            end
            c_ST_S0: begin
                w_selop  = 3'b110;
                w_mar_en = 1'b1;
            end
            c_ST_S1: begin
                w_busb   = ACC_ADDR;
                w_mdr_en = 1'b1;
            end
            c_ST_S2:   w_wr_rdn = 1'b1;
            c_ST_HALT: w_halted = 1'b1;
            default: ;
        endcase
        // Reset silences everything, including the INIT clear strobe.
        if (rst) begin
            w_wr_rdn     = 1'b0;
            w_enaf       = 1'b0;
            w_selop      = 3'b000;
            w_shamt      = 2'b00;
            w_bank_wr_en = 1'b0;
            w_busb       = '0;
            w_busc       = '0;
            w_sclr       = 1'b0;
            w_ir_en      = 1'b0;
            w_mar_en     = 1'b0;
            w_mdr_en     = 1'b0;
            w_mdr_alu_n  = 1'b0;
            w_halted     = 1'b0;
            w_illegal_op = 1'b0;
        end
    end

    assign ctrl.wr_rdn     = w_wr_rdn;
    assign ctrl.enaf       = w_enaf;
    assign ctrl.selop      = w_selop;
    assign ctrl.shamt      = w_shamt;
    assign ctrl.bank_wr_en = w_bank_wr_en;
    assign ctrl.BusB_addr  = w_busb;
    assign ctrl.BusC_addr  = w_busc;
    assign ctrl.sclr       = w_sclr;
    assign ctrl.ir_en      = w_ir_en;
    assign ctrl.mar_en     = w_mar_en;
    assign ctrl.mdr_en     = w_mdr_en;
    assign ctrl.mdr_alu_n  = w_mdr_alu_n;
    assign ctrl.halted     = w_halted;
    assign ctrl.illegal_op = w_illegal_op;

endmodule
`default_nettype wire

// File: tb/tb_pdua_control_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pdua_control_unit
//  Purpose  : Self-checking bench for the PDUA control unit.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pdua_control_unit;

    localparam logic [2:0] c_PC  = 3'b000;
    localparam logic [2:0] c_ACC = 3'b011;

    typedef struct packed {
        logic       wr_rdn;
        logic       enaf;
        logic [2:0] selop;
        logic [1:0] shamt;
        logic       bank_wr_en;
        logic [2:0] busb;
        logic [2:0] busc;
        logic       sclr;
        logic       ir_en;
        logic       mar_en;
        logic       mdr_en;
        logic       mdr_alu_n;
        logic       halted;
        logic       illegal_op;
    } ctrl_t;

    typedef struct {
        logic [4:0] op;
        logic       z;
        int         n_cycles;
        ctrl_t      last;
        string      name;
    } vec_t;

    logic  clk = 1'b0;
    logic  rst;
    int    checks   = 0;
    int    failures = 0;
    vec_t  tbl[$];
    ctrl_t exp_q[$];

    always #5 clk = ~clk;

    pdua_control_unit_if #(.ADDR_WIDTH(3)) bus ();

    pdua_control_unit #(
        .ADDR_WIDTH(3),
        .PC_ADDR   (3'b000),
        .ACC_ADDR  (3'b011)
    ) dut (
        .clk (clk),
        .rst (rst),
        .ctrl(bus)
    );

    function automatic ctrl_t mk(input logic [2:0] busb, input logic [2:0] busc,
                                 input logic [2:0] selop, input logic [1:0] shamt,
                                 input logic we, input logic enaf);
        ctrl_t v = '0;
        v.busb = busb; v.busc = busc; v.selop = selop; v.shamt = shamt;
        v.bank_wr_en = we; v.enaf = enaf;
        return v;
    endfunction

    function automatic ctrl_t v_init();
        ctrl_t v = '0; v.sclr = 1'b1; return v;
    endfunction
    function automatic ctrl_t v_f0();
        ctrl_t v = '0; v.busb = c_PC; v.mar_en = 1'b1; return v;
    endfunction
    function automatic ctrl_t v_f1();
        ctrl_t v = mk(c_PC, c_PC, 3'b001, 2'b00, 1'b1, 1'b0);
        v.mdr_en = 1'b1; v.mdr_alu_n = 1'b1; return v;
    endfunction
    function automatic ctrl_t v_f2();
        ctrl_t v = '0; v.ir_en = 1'b1; return v;
    endfunction
    function automatic ctrl_t v_dec(input logic ill);
        ctrl_t v = '0; v.illegal_op = ill; return v;
    endfunction
    function automatic ctrl_t v_s0();
        ctrl_t v = '0; v.selop = 3'b110; v.mar_en = 1'b1; return v;
    endfunction
    function automatic ctrl_t v_s1();
        ctrl_t v = '0; v.busb = c_ACC; v.mdr_en = 1'b1; return v;
    endfunction
    function automatic ctrl_t v_s2();
        ctrl_t v = '0; v.wr_rdn = 1'b1; return v;
    endfunction
    function automatic ctrl_t v_halt();
        ctrl_t v = '0; v.halted = 1'b1; return v;
    endfunction

    // Expands one instruction into its expected per-cycle strobe sequence.
    task automatic build(input logic [4:0] op, input logic z);
        logic legal = (op <= 5'd8) || (op == 5'd31);
        exp_q.delete();
        exp_q.push_back(v_f0());
        exp_q.push_back(v_f1());
        exp_q.push_back(v_f2());
        exp_q.push_back(v_dec(!legal));
        if (op inside {5'd1, 5'd2, 5'd3, 5'd6, 5'd8} || (op == 5'd7 && z)) begin
            exp_q.push_back(v_f0());
            exp_q.push_back(v_f1());
        end
        case (op)
            5'd1: exp_q.push_back(mk(c_PC, c_ACC, 3'b110, 2'b00, 1'b1, 1'b1));
            5'd2: exp_q.push_back(mk(c_ACC, c_ACC, 3'b010, 2'b00, 1'b1, 1'b1));
            5'd3: exp_q.push_back(mk(c_ACC, c_ACC, 3'b011, 2'b00, 1'b1, 1'b1));
            5'd4: exp_q.push_back(mk(c_ACC, c_ACC, 3'b100, 2'b00, 1'b1, 1'b1));
            5'd5: exp_q.push_back(mk(c_ACC, c_ACC, 3'b101, 2'b01, 1'b1, 1'b1));
            5'd6: exp_q.push_back(mk(c_PC, c_PC, 3'b110, 2'b00, 1'b1, 1'b0));
            5'd7: exp_q.push_back(z ? mk(c_PC, c_PC, 3'b110, 2'b00, 1'b1, 1'b0)
                                    : mk(c_PC, c_PC, 3'b001, 2'b00, 1'b1, 1'b0));
            5'd8: begin
                exp_q.push_back(v_s0());
                exp_q.push_back(v_s1());
                exp_q.push_back(v_s2());
            end
            default: ;
        endcase
    endtask

    function automatic ctrl_t sample();
        ctrl_t v;
        v.wr_rdn = bus.wr_rdn; v.enaf = bus.enaf; v.selop = bus.selop;
        v.shamt = bus.shamt; v.bank_wr_en = bus.bank_wr_en;
        v.busb = bus.BusB_addr; v.busc = bus.BusC_addr; v.sclr = bus.sclr;
        v.ir_en = bus.ir_en; v.mar_en = bus.mar_en; v.mdr_en = bus.mdr_en;
        v.mdr_alu_n = bus.mdr_alu_n; v.halted = bus.halted;
        v.illegal_op = bus.illegal_op;
        return v;
    endfunction

    // Opcode and flags only matter in the decode slot; elsewhere they are noise.
    task automatic drive(input logic is_dec, input logic [4:0] op, input logic z);
        bus.out_IR = is_dec ? op : 5'($urandom);
        bus.Z      = is_dec ? z  : 1'($urandom);
        bus.C      = 1'($urandom);
        bus.N      = 1'($urandom);
        bus.P      = 1'($urandom);
    endtask

    task automatic step(input logic chk, input ctrl_t exp, input string name);
        ctrl_t act;
        #1;
        act = sample();
        if (chk) begin
            checks++;
            if (act !== exp) begin
                failures++;
                $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
            end
        end
        @(negedge clk);
    endtask

    task automatic add_vec(input logic [4:0] op, input logic z, input int n,
                           input ctrl_t last, input string name);
        vec_t v;
        v.op = op; v.z = z; v.n_cycles = n; v.last = last; v.name = name;
        tbl.push_back(v);
    endtask

    initial begin
        add_vec(5'b00000, 1'b0, 4, v_dec(1'b0), "nop");
        add_vec(5'b00000, 1'b1, 4, v_dec(1'b0), "nop2");
        add_vec(5'b00001, 1'b0, 7, mk(c_PC, c_ACC, 3'b110, 2'b00, 1'b1, 1'b1), "ldi");
        add_vec(5'b00010, 1'b0, 7, mk(c_ACC, c_ACC, 3'b010, 2'b00, 1'b1, 1'b1), "addi");
        add_vec(5'b00011, 1'b1, 7, mk(c_ACC, c_ACC, 3'b011, 2'b00, 1'b1, 1'b1), "andi");
        add_vec(5'b00100, 1'b0, 5, mk(c_ACC, c_ACC, 3'b100, 2'b00, 1'b1, 1'b1), "not");
        add_vec(5'b00101, 1'b0, 5, mk(c_ACC, c_ACC, 3'b101, 2'b01, 1'b1, 1'b1), "shl");
        add_vec(5'b00110, 1'b0, 7, mk(c_PC, c_PC, 3'b110, 2'b00, 1'b1, 1'b0), "jmp");
        add_vec(5'b00111, 1'b1, 7, mk(c_PC, c_PC, 3'b110, 2'b00, 1'b1, 1'b0), "jz_taken");
        add_vec(5'b00111, 1'b0, 5, mk(c_PC, c_PC, 3'b001, 2'b00, 1'b1, 1'b0), "jz_skip");
        add_vec(5'b01000, 1'b0, 9, v_s2(), "sta");
        add_vec(5'b10101, 1'b0, 4, v_dec(1'b1), "illegal");
        add_vec(5'b00000, 1'b0, 4, v_dec(1'b0), "nop_after_illegal");

        // Reset held for two cycles, then the single INIT cycle.
        rst = 1'b1;
        drive(1'b0, 5'd0, 1'b0);
        @(negedge clk);
        step(1'b1, '0, "reset0");
        drive(1'b0, 5'd0, 1'b0);
        step(1'b1, '0, "reset1");
        rst = 1'b0;
        drive(1'b0, 5'd0, 1'b0);
        step(1'b1, v_init(), "init");

        // Table: check first cycle is F0 and the instruction's final cycle.
        foreach (tbl[k]) begin
            for (int i = 0; i < tbl[k].n_cycles; i++) begin
                drive(i == 3, tbl[k].op, tbl[k].z);
                if (i == 0)
                    step(1'b1, v_f0(), {tbl[k].name, "_f0"});
                else
                    step(i == tbl[k].n_cycles - 1, tbl[k].last, tbl[k].name);
            end
        end

        // Random instruction stream, every cycle compared against the model.
        for (int n = 0; n < 60; n++) begin
            logic [4:0] op;
            logic       z;
            op = 5'($urandom_range(0, 30));
            z  = 1'($urandom_range(0, 1));
            build(op, z);
            foreach (exp_q[i]) begin
                drive(i == 3, op, z);
                step(1'b1, exp_q[i], "rand");
            end
        end

        // Reset arrives while STA is in S1: no write may ever appear.
        build(5'b01000, 1'b0);
        for (int i = 0; i < 7; i++) begin
            drive(i == 3, 5'b01000, 1'b0);
            step(1'b1, exp_q[i], "sta_pre_rst");
        end
        rst = 1'b1;
        drive(1'b0, 5'd0, 1'b0);
        step(1'b1, '0, "rst_in_s1");
        drive(1'b0, 5'd0, 1'b0);
        step(1'b1, '0, "rst_hold");
        rst = 1'b0;
        drive(1'b0, 5'd0, 1'b0);
        step(1'b1, v_init(), "init_after_rst");

        // HALT: fetch/decode, then 20 cycles of halted with no strobes.
        build(5'b11111, 1'b0);
        foreach (exp_q[i]) begin
            drive(i == 3, 5'b11111, 1'b0);
            step(1'b1, exp_q[i], "halt_fetch");
        end
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 5'($urandom), 1'($urandom));
            step(1'b1, v_halt(), "halted");
        end
        rst = 1'b1;
        drive(1'b0, 5'd0, 1'b0);
        step(1'b1, '0, "halt_rst");
        rst = 1'b0;
        drive(1'b0, 5'd0, 1'b0);
        step(1'b1, v_init(), "halt_init");
        drive(1'b0, 5'd0, 1'b0);
        step(1'b1, v_f0(), "halt_f0");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
